// File: rtl/sprite_pkg.sv
// Shared types and command codes for the sprite memory controller.
package sprite_pkg;

  // Width of the address field carried in a queued pixel write.
  localparam int PIX_ADDR_W = 20;

  localparam logic [7:0] CMD_PIX_WR     = 8'hFD;
  localparam logic [7:0] CMD_PIX_WR_INC = 8'hFF;
  localparam logic [7:0] CMD_RQ_PUSH    = 8'hFC;
  localparam logic [7:0] CMD_RQ_CLEAR   = 8'hFE;
  localparam logic [7:0] CMD_CLR_STATUS = 8'hFA;

  typedef enum logic {
    GNT_VGA = 1'b0,
    GNT_WR  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [PIX_ADDR_W-1:0] addr;
    logic [23:0]           data;
  } pix_wr_t;

endpackage

// File: rtl/sprite_mem_ctrl_if.sv
// Host byte bus, display read port, image memory port and render-queue port.
interface sprite_mem_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic [7:0]        hps_writedata;
  logic              hps_write;
  logic              hps_chipselect;
  logic [2:0]        hps_address;
  logic              vga_rd_req;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic              vga_rd_valid;
  logic [23:0]       vga_rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [23:0]       mem_din;
  logic [23:0]       mem_dout;
  logic              rq_we;
  logic [47:0]       rq_din;
  logic              rq_full;
  logic              rq_clear;
  logic              wr_overflow;
  logic              rq_drop;

  modport master (
    output hps_writedata, hps_write, hps_chipselect, hps_address,
    output vga_rd_req, vga_rd_addr, mem_dout, rq_full,
    input  vga_rd_valid, vga_rd_data, mem_addr, mem_we, mem_din,
    input  rq_we, rq_din, rq_clear, wr_overflow, rq_drop
  );

  modport slave (
    input  hps_writedata, hps_write, hps_chipselect, hps_address,
    input  vga_rd_req, vga_rd_addr, mem_dout, rq_full,
    output vga_rd_valid, vga_rd_data, mem_addr, mem_we, mem_din,
    output rq_we, rq_din, rq_clear, wr_overflow, rq_drop
  );
endinterface

// File: rtl/sprite_mem_ctrl_fifo.sv
// Pending pixel-write FIFO; a push into a full FIFO is accepted only when
// the same cycle pops.
module pix_wr_fifo
  import sprite_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk50,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  pix_wr_t                din,
  output pix_wr_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  pix_wr_t          store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk50) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/sprite_mem_ctrl.sv
// Host command sequencer and image-memory port arbiter (display reads vs
// queued host pixel writes, with starvation-forced writes).
//
// state   | meaning
// GNT_VGA | display reads win; queued writes use idle cycles
// GNT_WR  | one forced write cycle after STARVE_LIMIT denied cycles
module sprite_mem_ctrl
  import sprite_pkg::*;
#(
  parameter int ADDR_W       = PIX_ADDR_W,
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 15
) (
  input logic              clk50,
  input logic              reset_n,
  sprite_mem_ctrl_if.slave bus
);
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int FCNT_W = $clog2(WFIFO_DEPTH) + 1;

  logic              host_acc;
  logic              cmd_acc;
  logic              pix_cmd;
  logic              pix_drop;
  logic [47:0]       stage;

  logic              rq_we;
  logic [47:0]       rq_din;
  logic              rq_clear;
  logic              wr_overflow;
  logic              rq_drop;
  logic              vga_rd_valid;

  arb_state_t        state;
  arb_state_t        next_state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_nxt;
  logic              rd_grant;
  logic              wr_issue;
  logic              wr_pending;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_din;
  logic              mem_we;

  pix_wr_t           push_entry;
  pix_wr_t           fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  assign host_acc = bus.hps_write && bus.hps_chipselect;
  assign cmd_acc  = host_acc && (bus.hps_address == 3'd0);
  assign pix_cmd  = cmd_acc && ((bus.hps_writedata == CMD_PIX_WR) ||
                                (bus.hps_writedata == CMD_PIX_WR_INC));
  // A full FIFO still takes the new entry when the arbiter pops this cycle.
  assign pix_drop = pix_cmd && fifo_full && !wr_issue;

  assign push_entry.addr = PIX_ADDR_W'(stage[ADDR_W-1:0]);
  assign push_entry.data = stage[47:24];

  pix_wr_fifo #(.DEPTH(WFIFO_DEPTH)) u_fifo (
    .clk50   (clk50),
    .reset_n (reset_n),
    .push    (pix_cmd),
    .pop     (wr_issue),
    .din     (push_entry),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
    end else if (host_acc) begin
      case (bus.hps_address)
        3'd1: stage[47:40] <= bus.hps_writedata;
        3'd2: stage[39:32] <= bus.hps_writedata;
        3'd3: stage[31:24] <= bus.hps_writedata;
        3'd4: stage[23:16] <= bus.hps_writedata;
        3'd5: stage[15:8]  <= bus.hps_writedata;
        3'd6: stage[7:0]   <= bus.hps_writedata;
        3'd0: begin
          if (bus.hps_writedata == CMD_PIX_WR_INC)
            stage[ADDR_W-1:0] <= stage[ADDR_W-1:0] + ADDR_W'(1);
        end
        default: stage <= stage;
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      rq_we       <= 1'b0;
      rq_din      <= '0;
      rq_clear    <= 1'b0;
      wr_overflow <= 1'b0;
      rq_drop     <= 1'b0;
    end else begin
      rq_we    <= 1'b0;
      rq_clear <= 1'b0;
      if (cmd_acc) begin
        case (bus.hps_writedata)
          CMD_RQ_PUSH: begin
            if (bus.rq_full) begin
              rq_drop <= 1'b1;
            end else begin
              rq_we  <= 1'b1;
              rq_din <= stage;
            end
          end
          CMD_RQ_CLEAR: rq_clear <= 1'b1;
          CMD_CLR_STATUS: begin
            wr_overflow <= 1'b0;
            rq_drop     <= 1'b0;
          end
          default: ;
        endcase
      end
      if (pix_drop) wr_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= GNT_VGA;
      starve_cnt   <= '0;
      vga_rd_valid <= 1'b0;
    end else begin
      state        <= next_state;
      starve_cnt   <= starve_nxt;
      vga_rd_valid <= rd_grant;
    end
  end

  assign wr_pending = (fifo_count != '0);

  always_comb begin
    next_state = state;
    starve_nxt = starve_cnt;
    case (state)
      GNT_VGA: begin
        if (!wr_pending) begin
          starve_nxt = '0;
        end else if (bus.vga_rd_req) begin
          starve_nxt = starve_cnt + CNT_W'(1);
          // Switch as the limit is reached so exactly STARVE_LIMIT reads win.
          if (starve_nxt == CNT_W'(STARVE_LIMIT)) next_state = GNT_WR;
        end else begin
          starve_nxt = '0;
        end
      end
      GNT_WR: begin
        starve_nxt = '0;
        next_state = GNT_VGA;
      end
      default: next_state = GNT_VGA;
    endcase
  end

  always_comb begin
    rd_grant = 1'b0;
    wr_issue = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    // Holding the port idle during reset keeps the memory address at zero.
    if (reset_n) begin
      case (state)
        GNT_VGA: begin
          if (bus.vga_rd_req)   rd_grant = 1'b1;
          else if (!fifo_empty) wr_issue = 1'b1;
        end
        GNT_WR:  wr_issue = !fifo_empty;
        default: ;
      endcase
    end
    if (rd_grant) begin
      mem_addr = bus.vga_rd_addr;
    end else if (wr_issue) begin
      mem_addr = ADDR_W'(fifo_head.addr);
      mem_din  = fifo_head.data;
      mem_we   = 1'b1;
    end
  end

  assign bus.mem_addr     = mem_addr;
  assign bus.mem_din      = mem_din;
  assign bus.mem_we       = mem_we;
  assign bus.vga_rd_valid = vga_rd_valid;
  assign bus.vga_rd_data  = bus.mem_dout;
  assign bus.rq_we        = rq_we;
  assign bus.rq_din       = rq_din;
  assign bus.rq_clear     = rq_clear;
  assign bus.wr_overflow  = wr_overflow;
  assign bus.rq_drop      = rq_drop;

endmodule

// File: tb/tb_sprite_mem_ctrl.sv
// Bench for sprite_mem_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_sprite_mem_ctrl;
  import sprite_pkg::*;

  localparam int AW     = 20;
  localparam int DEPTH  = 4;
  localparam int STARVE = 15;

  typedef struct {
    logic [AW-1:0] a;
    logic [23:0]   d;
  } wr_t;

  logic clk50   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk50 = ~clk50;

  sprite_mem_ctrl_if #(.ADDR_W(AW)) bus();

  sprite_mem_ctrl #(
    .ADDR_W(AW), .WFIFO_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)
  ) dut (
    .clk50   (clk50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Inputs change 2 units after a rising edge, outputs are sampled 4 after.
  task automatic cyc();
    @(posedge clk50);
    #2;
  endtask

  task automatic host_idle();
    bus.hps_write      = 1'b0;
    bus.hps_chipselect = 1'b0;
    bus.hps_address    = 3'd0;
    bus.hps_writedata  = 8'h00;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    bus.hps_address    = a;
    bus.hps_writedata  = d;
    bus.hps_write      = 1'b1;
    bus.hps_chipselect = 1'b1;
    cyc();
    host_idle();
  endtask

  task automatic load_stage(input logic [47:0] v);
    for (int i = 1; i <= 6; i++) host_wr(3'(i), v[8*(6-i) +: 8]);
  endtask

  task automatic apply_reset();
    reset_n          = 1'b0;
    host_idle();
    bus.vga_rd_req   = 1'b0;
    bus.vga_rd_addr  = '0;
    bus.mem_dout     = '0;
    bus.rq_full      = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    apply_reset();
    #2;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_din !== '0) begin errors++; $display("FAIL reset_mem_din got %h want 0", bus.mem_din); end
    checks++; if ({bus.rq_we, bus.rq_clear, bus.vga_rd_valid, bus.wr_overflow, bus.rq_drop} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000",
                         {bus.rq_we, bus.rq_clear, bus.vga_rd_valid, bus.wr_overflow, bus.rq_drop}); end
    checks++; if (bus.rq_din !== '0) begin errors++; $display("FAIL reset_rq_din got %h want 0", bus.rq_din); end
  endtask

  task automatic test_pix_write();
    bus.vga_rd_req = 1'b0;
    load_stage(48'h123456_000010);
    host_wr(3'd0, CMD_PIX_WR);
    #2;
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL pix_we got %b want 1", bus.mem_we); end
    checks++; if (bus.mem_addr !== 20'h00010) begin errors++; $display("FAIL pix_addr got %h want 00010", bus.mem_addr); end
    checks++; if (bus.mem_din !== 24'h123456) begin errors++; $display("FAIL pix_din got %h want 123456", bus.mem_din); end
    cyc(); #2;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL pix_we_after got %b want 0", bus.mem_we); end
  endtask

  task automatic test_auto_inc();
    logic [AW-1:0] exp_a [3];
    exp_a[0] = 20'hFFFFF; exp_a[1] = 20'h00000; exp_a[2] = 20'h00001;
    bus.vga_rd_req = 1'b0;
    bus.rq_full    = 1'b0;
    load_stage(48'hABCDEF_5FFFFF);
    bus.hps_address = 3'd0; bus.hps_writedata = CMD_PIX_WR_INC;
    bus.hps_write   = 1'b1; bus.hps_chipselect = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 2) host_idle();
      #2;
      if (k < 3) begin
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL inc_we[%0d] got %b want 1", k, bus.mem_we); end
        checks++; if (bus.mem_addr !== exp_a[k]) begin errors++; $display("FAIL inc_addr[%0d] got %h want %h", k, bus.mem_addr, exp_a[k]); end
        checks++; if (bus.mem_din !== 24'hABCDEF) begin errors++; $display("FAIL inc_din[%0d] got %h want abcdef", k, bus.mem_din); end
      end else begin
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL inc_idle got %b want 0", bus.mem_we); end
      end
    end
    host_wr(3'd0, CMD_RQ_PUSH);
    #2;
    checks++; if (bus.rq_din !== 48'hABCDEF_500002) begin errors++; $display("FAIL inc_stage got %h want abcdef500002", bus.rq_din); end
  endtask

  task automatic test_starvation();
    logic [AW-1:0] ra;
    logic [23:0]   rd;
    bit            granted_prev;
    bus.vga_rd_req  = 1'b1;
    bus.vga_rd_addr = 20'h00005;
    load_stage(48'h0A0B0C_000123);
    host_wr(3'd0, CMD_PIX_WR);
    granted_prev = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      ra = AW'($urandom);
      rd = 24'($urandom);
      bus.vga_rd_addr = ra;
      bus.mem_dout    = rd;
      #2;
      checks++; if (bus.vga_rd_valid !== granted_prev) begin errors++; $display("FAIL starve_valid[%0d] got %b want %b", k, bus.vga_rd_valid, granted_prev); end
      if (granted_prev) begin
        checks++; if (bus.vga_rd_data !== rd) begin errors++; $display("FAIL starve_rdata[%0d] got %h want %h", k, bus.vga_rd_data, rd); end
      end
      if (k == 16) begin
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL starve_forced_we got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 20'h00123) begin errors++; $display("FAIL starve_forced_addr got %h want 00123", bus.mem_addr); end
        checks++; if (bus.mem_din !== 24'h0A0B0C) begin errors++; $display("FAIL starve_forced_din got %h want 0a0b0c", bus.mem_din); end
      end else begin
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL starve_we[%0d] got %b want 0", k, bus.mem_we); end
        checks++; if (bus.mem_addr !== ra) begin errors++; $display("FAIL starve_raddr[%0d] got %h want %h", k, bus.mem_addr, ra); end
      end
      granted_prev = (k != 16);
      cyc();
    end
  endtask

  task automatic test_overflow();
    int n_wr;
    bus.vga_rd_req = 1'b1;
    for (int k = 0; k < 4; k++) host_wr(3'd0, CMD_PIX_WR);
    #2;
    checks++; if (bus.wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b want 0", bus.wr_overflow); end
    host_wr(3'd0, CMD_PIX_WR);
    #2;
    checks++; if (bus.wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.wr_overflow); end
    host_wr(3'd0, CMD_CLR_STATUS);
    bus.vga_rd_req = 1'b0;
    #2;
    checks++; if (bus.wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", bus.wr_overflow); end
    n_wr = int'(bus.mem_we);
    for (int k = 0; k < 11; k++) begin
      cyc(); #2;
      n_wr += int'(bus.mem_we);
    end
    checks++; if (n_wr != DEPTH) begin errors++; $display("FAIL ovf_drain got %0d writes want %0d", n_wr, DEPTH); end
  endtask

  task automatic test_rq();
    bus.vga_rd_req = 1'b0;
    bus.rq_full    = 1'b1;
    load_stage(48'hFEDCBA_987654);
    host_wr(3'd0, CMD_RQ_PUSH);
    #2;
    checks++; if (bus.rq_we !== 1'b0) begin errors++; $display("FAIL rq_full_we got %b want 0", bus.rq_we); end
    checks++; if (bus.rq_drop !== 1'b1) begin errors++; $display("FAIL rq_drop_set got %b want 1", bus.rq_drop); end
    host_wr(3'd0, CMD_CLR_STATUS);
    #2;
    checks++; if (bus.rq_drop !== 1'b0) begin errors++; $display("FAIL rq_drop_clear got %b want 0", bus.rq_drop); end
    bus.rq_full = 1'b0;
    host_wr(3'd0, CMD_RQ_PUSH);
    #2;
    checks++; if (bus.rq_we !== 1'b1) begin errors++; $display("FAIL rq_we got %b want 1", bus.rq_we); end
    checks++; if (bus.rq_din !== 48'hFEDCBA_987654) begin errors++; $display("FAIL rq_din got %h want fedcba987654", bus.rq_din); end
    cyc(); #2;
    checks++; if (bus.rq_we !== 1'b0) begin errors++; $display("FAIL rq_we_pulse got %b want 0", bus.rq_we); end
    host_wr(3'd7, 8'h99);
    host_wr(3'd0, CMD_RQ_PUSH);
    #2;
    checks++; if (bus.rq_din !== 48'hFEDCBA_987654) begin errors++; $display("FAIL addr7_ignored got %h want fedcba987654", bus.rq_din); end
    host_wr(3'd0, CMD_RQ_CLEAR);
    #2;
    checks++; if (bus.rq_clear !== 1'b1) begin errors++; $display("FAIL rq_clear got %b want 1", bus.rq_clear); end
    cyc(); #2;
    checks++; if (bus.rq_clear !== 1'b0) begin errors++; $display("FAIL rq_clear_pulse got %b want 0", bus.rq_clear); end
  endtask

  task automatic test_reset_mid();
    int n_wr;
    bus.vga_rd_req = 1'b1;
    bus.rq_full    = 1'b1;
    for (int k = 0; k < 3; k++) host_wr(3'd0, CMD_PIX_WR);
    host_wr(3'd0, CMD_RQ_PUSH);
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.mem_we, bus.rq_we, bus.rq_clear, bus.vga_rd_valid, bus.wr_overflow, bus.rq_drop} !== 6'b0) begin
      errors++; $display("FAIL midrst_flags got %b want 000000",
                         {bus.mem_we, bus.rq_we, bus.rq_clear, bus.vga_rd_valid, bus.wr_overflow, bus.rq_drop}); end
    checks++; if (bus.mem_addr !== '0 || bus.mem_din !== '0) begin errors++; $display("FAIL midrst_mem got %h/%h want 0/0", bus.mem_addr, bus.mem_din); end
    checks++; if (bus.rq_din !== '0) begin errors++; $display("FAIL midrst_rq_din got %h want 0", bus.rq_din); end
    bus.vga_rd_req = 1'b0;
    bus.rq_full    = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    n_wr = 0;
    for (int k = 0; k < 20; k++) begin
      #2;
      n_wr += int'(bus.mem_we);
      cyc();
    end
    checks++; if (n_wr != 0) begin errors++; $display("FAIL midrst_no_write got %0d writes want 0", n_wr); end
  endtask

  function automatic logic [7:0] pick_cmd();
    case ($urandom_range(0, 7))
      0, 1:    return CMD_PIX_WR;
      2, 3:    return CMD_PIX_WR_INC;
      4:       return CMD_RQ_PUSH;
      5:       return CMD_RQ_CLEAR;
      6:       return CMD_CLR_STATUS;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [47:0] st;
    logic [47:0] erqd;
    wr_t         q[$];
    wr_t         e;
    int          denied;
    int          pct;
    bit          ovf, drp, ev, erq, eclr;
    bit          req, acc, rd, wr, forced;
    apply_reset();
    st = '0; erqd = '0; q.delete(); denied = 0; pct = 50;
    ovf = 0; drp = 0; ev = 0; erq = 0; eclr = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        case ((i / 100) % 4)
          0:       pct = 5;
          1:       pct = 50;
          2:       pct = 90;
          default: pct = 100;
        endcase
      end
      req = ($urandom_range(0, 99) < pct);
      bus.vga_rd_req     = req;
      bus.vga_rd_addr    = AW'($urandom);
      bus.mem_dout       = 24'($urandom);
      bus.rq_full        = ($urandom_range(0, 3) == 0);
      bus.hps_write      = 1'($urandom_range(0, 1));
      bus.hps_chipselect = ($urandom_range(0, 4) != 0);
      bus.hps_address    = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(1, 7));
      bus.hps_writedata  = (bus.hps_address == 3'd0) ? pick_cmd() : 8'($urandom);
      #2;
      checks++; if (bus.vga_rd_valid !== ev) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.vga_rd_valid, ev); end
      checks++; if (bus.rq_we !== erq) begin errors++; $display("FAIL rnd_rq_we[%0d] got %b want %b", i, bus.rq_we, erq); end
      if (erq) begin
        checks++; if (bus.rq_din !== erqd) begin errors++; $display("FAIL rnd_rq_din[%0d] got %h want %h", i, bus.rq_din, erqd); end
      end
      checks++; if (bus.rq_clear !== eclr) begin errors++; $display("FAIL rnd_rq_clear[%0d] got %b want %b", i, bus.rq_clear, eclr); end
      checks++; if ({bus.wr_overflow, bus.rq_drop} !== {ovf, drp}) begin errors++; $display("FAIL rnd_sticky[%0d] got %b%b want %b%b", i, bus.wr_overflow, bus.rq_drop, ovf, drp); end

      forced = (denied == STARVE) && (q.size() != 0);
      rd     = !forced && req;
      wr     = forced || (!req && q.size() != 0);
      checks++; if (bus.mem_we !== wr) begin errors++; $display("FAIL rnd_mem_we[%0d] got %b want %b", i, bus.mem_we, wr); end
      if (wr) begin
        checks++; if (bus.mem_addr !== q[0].a || bus.mem_din !== q[0].d) begin errors++;
          $display("FAIL rnd_wr[%0d] got %h/%h want %h/%h", i, bus.mem_addr, bus.mem_din, q[0].a, q[0].d); end
      end else if (rd) begin
        checks++; if (bus.mem_addr !== bus.vga_rd_addr) begin errors++; $display("FAIL rnd_raddr[%0d] got %h want %h", i, bus.mem_addr, bus.vga_rd_addr); end
      end

      if (wr) begin
        void'(q.pop_front());
        denied = 0;
      end else if (q.size() == 0) begin
        denied = 0;
      end else begin
        denied++;
      end
      ev = rd; erq = 0; eclr = 0;
      acc = bus.hps_write && bus.hps_chipselect;
      if (acc) begin
        case (bus.hps_address)
          3'd0: begin
            case (bus.hps_writedata)
              CMD_PIX_WR, CMD_PIX_WR_INC: begin
                if (q.size() < DEPTH) begin
                  e.a = st[AW-1:0];
                  e.d = st[47:24];
                  q.push_back(e);
                end else begin
                  ovf = 1;
                end
                if (bus.hps_writedata == CMD_PIX_WR_INC) st[AW-1:0] = st[AW-1:0] + 1'b1;
              end
              CMD_RQ_PUSH: begin
                if (bus.rq_full) drp = 1;
                else begin erq = 1; erqd = st; end
              end
              CMD_RQ_CLEAR:   eclr = 1;
              CMD_CLR_STATUS: begin ovf = 0; drp = 0; end
              default: ;
            endcase
          end
          3'd7: ;
          default: st[8*(6-int'(bus.hps_address)) +: 8] = bus.hps_writedata;
        endcase
      end
      cyc();
    end
    host_idle();
    bus.vga_rd_req = 1'b0;
  endtask

  initial begin
    host_idle();
    bus.vga_rd_req  = 1'b0;
    bus.vga_rd_addr = '0;
    bus.mem_dout    = '0;
    bus.rq_full     = 1'b0;
    test_reset();
    test_pix_write();
    test_auto_inc();
    test_starvation();
    test_overflow();
    test_rq();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
